// File: rtl/nrisc_ddata_arbiter_pkg.sv
// Shared constants and types for the data-memory port arbiter.
// Holds widths, the starvation limit and the state encodings used by the arbiter and its bench.
package nrisc_ddata_arbiter_pkg;

    localparam int TAM           = 16;
    localparam int N_DDATA       = 8;
    localparam int ARB_MAX_WAIT  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_CMD_C = 2'd1,
        ARB_CMD_B = 2'd2
    } arb_state_e;

    // Owner of the load whose data returns in the following cycle.
    typedef enum logic {
        TAG_C = 1'b0,
        TAG_B = 1'b1
    } rd_tag_e;

    // Fixed core priority, overridden in favour of the bus once it has been starved.
    function automatic arb_state_e pick_winner(input logic c_req,
                                               input logic b_req,
                                               input logic starved);
        arb_state_e w;
        w = ARB_IDLE;
        if (c_req && b_req) begin
            w = starved ? ARB_CMD_B : ARB_CMD_C;
        end else if (c_req) begin
            w = ARB_CMD_C;
        end else if (b_req) begin
            w = ARB_CMD_B;
        end
        return w;
    endfunction

endpackage

// File: rtl/nrisc_ddata_arbiter_if.sv
// Master-side request port and memory-side command port of the data-memory arbiter.
// Handshake: a master raises req with we/addr/wdata stable and holds them until gnt pulses for one cycle;
// a load returns rdata one cycle after gnt, qualified by a single-cycle rvalid. There is no back-pressure.
interface nrisc_ddata_arbiter_if;
    import nrisc_ddata_arbiter_pkg::*;

    logic           req;
    logic           we;
    logic [TAM-1:0] addr;
    logic [TAM-1:0] wdata;
    logic           gnt;
    logic           rvalid;
    logic [TAM-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

interface nrisc_ddata_mem_if;
    import nrisc_ddata_arbiter_pkg::*;

    logic [TAM-1:0] addr;
    logic [TAM-1:0] wdata;
    logic           load;
    logic           write;
    logic [TAM-1:0] rdata;

    modport master (output addr, wdata, load, write, input rdata);
    modport slave  (input addr, wdata, load, write, output rdata);

endinterface

// File: rtl/nrisc_ddata_arbiter.sv
// Arbitrates the single data-memory port between the core (c) and the bus/DMA master (b).
// Core has fixed priority; a saturating wait counter forces a bus win after MAX_WAIT lost cycles.
module nrisc_ddata_arbiter
    import nrisc_ddata_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic                          clk,
    input  logic                          rst,
    nrisc_ddata_arbiter_if.slave          c,
    nrisc_ddata_arbiter_if.slave          b,
    nrisc_ddata_mem_if.master             m,
    output arb_state_e                    dbg_state,
    output logic [$clog2(MAX_WAIT+1)-1:0] dbg_wait_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    arb_state_e        state;
    arb_state_e        next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] next_wait;
    logic              starved;
    logic              rd_valid;
    rd_tag_e           rd_tag;

    assign starved = (wait_cnt == WAIT_W'(MAX_WAIT));

    always_comb begin
        next_state = pick_winner(c.req, b.req, starved);
        next_wait  = '0;
        if (b.req && next_state == ARB_CMD_C) begin
            next_wait = starved ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    // The command cycle outputs are registered from the decision; the read tag
    // is captured from the command cycle so a new grant may overlap the return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            wait_cnt <= '0;
            rd_valid <= 1'b0;
            rd_tag   <= TAG_C;
            c.gnt    <= 1'b0;
            b.gnt    <= 1'b0;
            m.addr   <= '0;
            m.wdata  <= '0;
            m.load   <= 1'b0;
            m.write  <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait;
            rd_valid <= m.load;
            rd_tag   <= (state == ARB_CMD_B) ? TAG_B : TAG_C;
            c.gnt    <= (next_state == ARB_CMD_C);
            b.gnt    <= (next_state == ARB_CMD_B);
            case (next_state)
                ARB_CMD_C: begin
                    m.addr  <= c.addr;
                    m.wdata <= c.wdata;
                    m.load  <= ~c.we;
                    m.write <= c.we;
                end
                ARB_CMD_B: begin
                    m.addr  <= b.addr;
                    m.wdata <= b.wdata;
                    m.load  <= ~b.we;
                    m.write <= b.we;
                end
                default: begin
                    m.addr  <= '0;
                    m.wdata <= '0;
                    m.load  <= 1'b0;
                    m.write <= 1'b0;
                end
            endcase
        end
    end

    assign c.rvalid = rd_valid && (rd_tag == TAG_C);
    assign b.rvalid = rd_valid && (rd_tag == TAG_B);
    assign c.rdata  = m.rdata;
    assign b.rdata  = m.rdata;

    assign dbg_state    = state;
    assign dbg_wait_cnt = wait_cnt;

    a_one_gnt : assert property (@(posedge clk) disable iff (!rst) !(c.gnt && b.gnt));
    a_wait_bound : assert property (@(posedge clk) disable iff (!rst) wait_cnt <= WAIT_W'(MAX_WAIT));

endmodule
